// File: rtl/mac8_pkg.sv
// Shared constants, FSM encoding and carry-save helper for the 8x8 signed MAC.
package mac8_pkg;

   localparam int unsigned OpW     = 8;
   localparam int unsigned ProdW   = 16;  // product width before sign extension to ACC_W
   localparam int unsigned PpRows  = 9;   // 8 partial products plus the two's-complement +1 row
   localparam logic [7:0]  CountMax = 8'hFF;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StAccum = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

   typedef struct packed {
      logic [ProdW-1:0] s;
      logic [ProdW-1:0] c;
   } csa_t;

   // 3:2 compressor applied bitwise across a whole row.
   function automatic csa_t csa(input logic [ProdW-1:0] x,
                                input logic [ProdW-1:0] y,
                                input logic [ProdW-1:0] z);
      csa_t r;
      r.s = x ^ y ^ z;
      r.c = ((x & y) | (x & z) | (y & z)) << 1;
      return r;
   endfunction

endpackage

// File: rtl/multiply8_signed_wallace_tree.sv
// 8x8 two's-complement multiplier: partial-product rows reduced by a carry-save tree,
// finished with a single carry-propagate add.
module multiply8_signed_wallace_tree
   import mac8_pkg::*;
(
   input  logic signed [OpW-1:0]   a_i,
   input  logic signed [OpW-1:0]   b_i,
   output logic signed [ProdW-1:0] prod_o
);

   logic [ProdW-1:0] a_ext;
   logic [ProdW-1:0] pp [PpRows];
   csa_t             l1_0, l1_1, l1_2;
   csa_t             l2_0, l2_1;
   csa_t             l3, l4;

   assign a_ext = ProdW'(a_i);

   // The sign bit of b carries weight -2^7, so that row is negated as ~x + 1.
   always_comb begin
      for (int i = 0; i < OpW - 1; i++) begin
         pp[i] = b_i[i] ? (a_ext << i) : '0;
      end
      pp[OpW-1] = b_i[OpW-1] ? ~(a_ext << (OpW - 1)) : '0;
      pp[OpW]   = ProdW'(b_i[OpW-1]);
   end

   always_comb begin
      l1_0 = csa(pp[0], pp[1], pp[2]);
      l1_1 = csa(pp[3], pp[4], pp[5]);
      l1_2 = csa(pp[6], pp[7], pp[8]);
      l2_0 = csa(l1_0.s, l1_0.c, l1_1.s);
      l2_1 = csa(l1_1.c, l1_2.s, l1_2.c);
      l3   = csa(l2_0.s, l2_0.c, l2_1.s);
      l4   = csa(l3.s, l3.c, l2_1.c);
   end

   assign prod_o = l4.s + l4.c;

endmodule

// File: rtl/mac8_signed_accumulator.sv
// Streaming 8-bit signed dot-product accumulator with valid/ready handshakes.
// Define MAC8_SAT_EN for saturating accumulation with a sticky overflow flag.
module mac8_signed_accumulator
   import mac8_pkg::*;
#(
   parameter int unsigned ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [7:0]       out_count,
   output logic             out_ovf
);

   state_e                  state_q, state_d;
   logic                    p_valid_q;
   logic signed [OpW-1:0]   a_q, b_q;
   logic                    last_q;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic [7:0]              count_q, count_d;
   logic signed [ProdW-1:0] prod;
   logic [ACC_W-1:0]        prod_ext;
   logic [ACC_W-1:0]        sum;
   logic                    accept;
   logic                    release_res;

   multiply8_signed_wallace_tree u_mult (
      .a_i    (a_q),
      .b_i    (b_q),
      .prod_o (prod)
   );

   assign prod_ext    = ACC_W'(prod);
   assign sum         = acc_q + prod_ext;
   assign in_ready    = (state_q == StIdle) || (state_q == StAccum);
   assign out_valid   = (state_q == StDone);
   assign accept      = in_valid && in_ready;
   assign release_res = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StAccum: begin
            if (accept) state_d = in_last ? StDrain : StAccum;
         end
         StDrain: begin
            if (p_valid_q && last_q) state_d = StDone;
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef MAC8_SAT_EN
   logic ovf_q, ovf_d;
   logic add_ovf;

   // Signed overflow: both addends share a sign that the sum does not.
   assign add_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

   always_comb begin
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (release_res) begin
         acc_d   = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (p_valid_q) begin
         count_d = (count_q == CountMax) ? count_q : count_q + 8'd1;
         if (add_ovf) begin
            acc_d = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            ovf_d = 1'b1;
         end else begin
            acc_d = sum;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign out_ovf = ovf_q;
`else
   always_comb begin
      acc_d   = acc_q;
      count_d = count_q;
      if (release_res) begin
         acc_d   = '0;
         count_d = '0;
      end else if (p_valid_q) begin
         acc_d   = sum;
         count_d = (count_q == CountMax) ? count_q : count_q + 8'd1;
      end
   end

   assign out_ovf = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         p_valid_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         last_q    <= 1'b0;
         acc_q     <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         p_valid_q <= accept;
         if (accept) begin
            a_q    <= in_a;
            b_q    <= in_b;
            last_q <= in_last;
         end
         acc_q   <= acc_d;
         count_q <= count_d;
      end
   end

   assign out_acc   = acc_q;
   assign out_count = count_q;

endmodule

// File: tb/tb_mac8_signed_accumulator.sv
// Directed bench: one 24-bit and one 16-bit accumulator driven with identical beats.
module tb_mac8_signed_accumulator;

`ifdef MAC8_SAT_EN
   localparam bit Sat = 1'b1;
`else
   localparam bit Sat = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, in_valid, in_last, out_ready;
   logic [7:0]  in_a, in_b;
   logic        rdy24, rdy16, ov24, ov16, ovf24, ovf16;
   logic [23:0] acc24;
   logic [15:0] acc16;
   logic [7:0]  cnt24, cnt16;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mac8_signed_accumulator #(.ACC_W(24)) dut24 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy24), .in_a(in_a), .in_b(in_b),
      .in_last(in_last), .out_valid(ov24), .out_ready(out_ready), .out_acc(acc24),
      .out_count(cnt24), .out_ovf(ovf24)
   );

   mac8_signed_accumulator #(.ACC_W(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .in_a(in_a), .in_b(in_b),
      .in_last(in_last), .out_valid(ov16), .out_ready(out_ready), .out_acc(acc16),
      .out_count(cnt16), .out_ovf(ovf16)
   );

   typedef struct packed {
      int unsigned     n;
      logic [3:0][7:0] a;     // beat j in byte j
      logic [3:0][7:0] b;
      int              exp24;
      int              exp16;
      logic [7:0]      cnt;
      logic            ovf16;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_result(input string tag, input int e24, input int e16,
                               input logic [7:0] c, input logic o16);
      chk({tag, " out_valid24"}, ov24, 1);
      chk({tag, " out_valid16"}, ov16, 1);
      chk({tag, " acc24"}, $signed(acc24), e24);
      chk({tag, " acc16"}, $signed(acc16), e16);
      chk({tag, " count24"}, cnt24, c);
      chk({tag, " count16"}, cnt16, c);
      chk({tag, " ovf24"}, ovf24, 0);
      chk({tag, " ovf16"}, ovf16, o16);
   endtask

   task automatic release_and_check(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, " idle out_valid"}, ov24, 0);
      chk({tag, " idle in_ready"}, rdy24, 1);
      chk({tag, " cleared acc24"}, $signed(acc24), 0);
      chk({tag, " cleared acc16"}, $signed(acc16), 0);
      chk({tag, " cleared count"}, cnt24, 0);
      chk({tag, " cleared ovf16"}, ovf16, 0);
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      for (int j = 0; j < int'(v.n); j++) begin
         in_valid = 1'b1;
         in_a     = v.a[j];
         in_b     = v.b[j];
         in_last  = (j == int'(v.n) - 1);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk({tag, " drain out_valid"}, ov24, 0);
      chk({tag, " drain in_ready"}, rdy24, 0);
      tick();
      check_result(tag, v.exp24, v.exp16, v.cnt, v.ovf16);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;

      tbl[0] = '{n: 1, a: {8'h00, 8'h00, 8'h00, 8'h80}, b: {8'h00, 8'h00, 8'h00, 8'h80},
                 exp24: 16384, exp16: 16384, cnt: 8'd1, ovf16: 1'b0};
      tbl[1] = '{n: 3, a: {8'h00, 8'h7f, 8'hfc, 8'h02}, b: {8'h00, 8'h7f, 8'h05, 8'h03},
                 exp24: 16115, exp16: 16115, cnt: 8'd3, ovf16: 1'b0};
      tbl[2] = '{n: 3, a: {8'h00, 8'h7f, 8'h7f, 8'h7f}, b: {8'h00, 8'h7f, 8'h7f, 8'h7f},
                 exp24: 48387, exp16: Sat ? 32767 : -17149, cnt: 8'd3, ovf16: Sat};
      tbl[3] = '{n: 2, a: {8'h00, 8'h00, 8'h7f, 8'hff}, b: {8'h00, 8'h00, 8'h80, 8'hff},
                 exp24: -16255, exp16: -16255, cnt: 8'd2, ovf16: 1'b0};
      tbl[4] = '{n: 4, a: {8'h80, 8'h80, 8'h80, 8'h80}, b: {8'h7f, 8'h7f, 8'h7f, 8'h7f},
                 exp24: -65024, exp16: Sat ? -32768 : 512, cnt: 8'd4, ovf16: Sat};
      tbl[5] = '{n: 1, a: {8'h00, 8'h00, 8'h00, 8'h00}, b: {8'h00, 8'h00, 8'h00, 8'h37},
                 exp24: 0, exp16: 0, cnt: 8'd1, ovf16: 1'b0};

      #2;
      chk("reset out_valid", ov24, 0);
      chk("reset acc24", $signed(acc24), 0);
      chk("reset count", cnt16, 0);
      chk("reset ovf16", ovf16, 0);
      #10 rst = 1'b0;
      tick();
      chk("post-reset in_ready", rdy24, 1);

      for (int i = 0; i < 6; i++) begin
         run_vec($sformatf("vec%0d", i), tbl[i]);
         release_and_check($sformatf("vec%0d", i));
      end

      // Result held while out_ready is low; offered beats must be refused.
      run_vec("hold", '{n: 1, a: {24'h0, 8'h03}, b: {24'h0, 8'hf9},
                        exp24: -21, exp16: -21, cnt: 8'd1, ovf16: 1'b0});
      in_valid = 1'b1; in_a = 8'd5; in_b = 8'd5; in_last = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("hold in_ready", rdy24, 0);
         chk("hold out_valid", ov16, 1);
         chk("hold acc24", $signed(acc24), -21);
         chk("hold count", cnt24, 1);
      end
      in_valid = 1'b0; in_last = 1'b0;
      release_and_check("hold");
      tick();
      tick();
      chk("hold no stale beat acc", $signed(acc24), 0);
      chk("hold no stale beat valid", ov24, 0);

      // Reset in the middle of a dot product discards the partial sum.
      in_valid = 1'b1; in_a = 8'd10; in_b = 8'd10; in_last = 1'b0;
      tick();
      in_a = 8'd20; in_b = 8'd20;
      tick();
      in_valid = 1'b0;
      chk("midrst running acc", $signed(acc24), 100);
      #2 rst = 1'b1;
      #1;
      chk("midrst acc cleared", $signed(acc24), 0);
      chk("midrst count cleared", cnt24, 0);
      chk("midrst out_valid", ov24, 0);
      #1 rst = 1'b0;
      tick();
      chk("midrst in_ready", rdy24, 1);
      run_vec("midrst", '{n: 1, a: {24'h0, 8'hff}, b: {24'h0, 8'hff},
                          exp24: 1, exp16: 1, cnt: 8'd1, ovf16: 1'b0});
      release_and_check("midrst");

      // Term counter saturates at 255 while the sum keeps growing.
      for (int j = 0; j < 260; j++) begin
         in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1; in_last = (j == 259);
         tick();
      end
      in_valid = 1'b0; in_last = 1'b0;
      tick();
      check_result("countsat", 260, 260, 8'd255, 1'b0);
      release_and_check("countsat");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
